// File: rtl/ti_nibble_sharer.sv
// ti_nibble_sharer
// ----------------
// Front end of the 4-bit threshold-implementation S-box. Takes unmasked
// nibbles over a valid/ready handshake, splits each into two Boolean shares
// with a fresh mask drawn from an internal 16-bit Galois LFSR, and presents
// the registered share pair in the layout the share functions consume.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in_valid_i nibble present
//   in_data_i  unmasked nibble x
//   in_ready_o block accepts in_data_i this cycle
//   reseed_i   one-cycle pulse: load seed_in_i (or SEED if zero), re-warm
//   seed_in_i  new LFSR seed, sampled while reseed_i = 1
//   out_valid_o out_share_o holds a valid pair
//   out_share_o [3:0] = x ^ m (share 0), [7:4] = m (share 1)
//   out_ready_i downstream accepts out_share_o
//   pair_cnt_o number of accepted pairs, wraps modulo 2^CNT_WIDTH
//   busy_o     high while the LFSR is warming up
module ti_nibble_sharer #(
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          WARMUP_CYCLES = 4,
    parameter int          CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    input  logic [3:0]           in_data_i,
    output logic                 in_ready_o,
    input  logic                 reseed_i,
    input  logic [15:0]          seed_in_i,
    output logic                 out_valid_o,
    output logic [7:0]           out_share_o,
    input  logic                 out_ready_i,
    output logic [CNT_WIDTH-1:0] pair_cnt_o,
    output logic                 busy_o
);

    typedef enum logic {
        S_WARMUP = 1'b0,
        S_RUN    = 1'b1
    } state_t;

    localparam logic [7:0] WARM_N  = 8'(WARMUP_CYCLES);
    localparam logic [8:0] WARM_N9 = 9'(WARMUP_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [7:0]             wcnt_q, wcnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [7:0]             out_share_q, out_share_d;
    logic [CNT_WIDTH-1:0]   pair_cnt_q, pair_cnt_d;

    logic                   in_ready_w;
    logic                   accept_w;
    logic                   pop_w;
    logic [3:0]             mask_w;
    logic [8:0]             wcnt_inc_w;

    // Right-shift Galois LFSR, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    assign mask_w     = lfsr_q[3:0];
    assign accept_w   = in_valid_i && in_ready_w;
    assign pop_w      = out_valid_q && out_ready_i;
    assign wcnt_inc_w = {1'b0, wcnt_q} + 9'd1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_WARMUP;
            lfsr_q      <= SEED;
            wcnt_q      <= 8'd0;
            out_valid_q <= 1'b0;
            out_share_q <= 8'h00;
            pair_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            wcnt_q      <= wcnt_d;
            out_valid_q <= out_valid_d;
            out_share_q <= out_share_d;
            pair_cnt_q  <= pair_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        wcnt_d      = wcnt_q;
        out_valid_d = out_valid_q;
        out_share_d = out_share_q;
        pair_cnt_d  = pair_cnt_q;

        if (reseed_i) begin
            // A zero seed would lock the LFSR, so fall back to SEED.
            lfsr_d  = (seed_in_i == 16'h0000) ? SEED : seed_in_i;
            wcnt_d  = 8'd0;
            state_d = S_WARMUP;
        end else begin
            case (state_q)
                S_WARMUP: begin
                    if (wcnt_q == WARM_N) begin
                        // Only reachable with a zero-length warm-up.
                        state_d = S_RUN;
                    end else begin
                        lfsr_d = lfsr_step(lfsr_q);
                        wcnt_d = wcnt_inc_w[7:0];
                        // Leave on the edge that takes the last step.
                        if (wcnt_inc_w == WARM_N9)
                            state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept_w)
                        lfsr_d = lfsr_step(lfsr_q);
                end
                default: state_d = S_WARMUP;
            endcase
        end

        // Output register: a simultaneous pop and accept just replaces
        // the entry, so out_valid stays high.
        if (accept_w) begin
            out_share_d = {mask_w, in_data_i ^ mask_w};
            out_valid_d = 1'b1;
            pair_cnt_d  = pair_cnt_q + CNT_ONE;
        end else if (pop_w) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready_w = (state_q == S_RUN) && !reseed_i &&
                     (!out_valid_q || out_ready_i);
        busy_o     = (state_q == S_WARMUP);
    end

    assign in_ready_o  = in_ready_w;
    assign out_valid_o = out_valid_q;
    assign out_share_o = out_share_q;
    assign pair_cnt_o  = pair_cnt_q;

endmodule

// File: tb/tb_ti_nibble_sharer.sv
module tb_ti_nibble_sharer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       reseed;
    logic [15:0] seed_in;
    logic       out_valid;
    logic [7:0] out_share;
    logic       out_ready;
    logic [3:0] pair_cnt;
    logic       busy;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ti_nibble_sharer #(
        .SEED(16'hACE1), .WARMUP_CYCLES(4), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .reseed_i(reseed), .seed_in_i(seed_in),
        .out_valid_o(out_valid), .out_share_o(out_share),
        .out_ready_i(out_ready), .pair_cnt_o(pair_cnt), .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         acc;
        int         cyc;
        int         waitc;
        logic [3:0] x;
        logic [3:0] q[$];

        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; reseed = 1'b0;
        seed_in = 16'h0000; out_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_share", {24'd0, out_share}, 32'h00);
        chk("rst_pair_cnt", {28'd0, pair_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);

        // Warm-up: busy for exactly 4 cycles
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("warm_busy", {31'd0, busy}, 32'd1);
            chk("warm_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        chk("run_busy", {31'd0, busy}, 32'd0);
        chk("run_in_ready", {31'd0, in_ready}, 32'd1);

        // lfsr = 1C4E -> m=E: x=5 -> EB ; lfsr = 0E27 -> m=7: x=0 -> 77
        out_ready = 1'b1; in_valid = 1'b1; in_data = 4'h5;
        tick();
        chk("p1_valid", {31'd0, out_valid}, 32'd1);
        chk("p1_share", {24'd0, out_share}, 32'hEB);
        chk("p1_cnt", {28'd0, pair_cnt}, 32'd1);
        in_data = 4'h0;
        tick();
        chk("p2_share", {24'd0, out_share}, 32'h77);
        chk("p2_cnt", {28'd0, pair_cnt}, 32'd2);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // lfsr = B313 -> m=3: x=9 -> 3A, held with out_ready = 0
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h9;
        tick();
        chk("p3_share", {24'd0, out_share}, 32'h3A);
        chk("p3_cnt", {28'd0, pair_cnt}, 32'd3);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);

        // Reseed with zero while the pair is pending
        reseed = 1'b1; seed_in = 16'h0000; in_data = 4'h5;
        #1;
        chk("reseed_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        reseed = 1'b0;
        chk("reseed_share_kept", {24'd0, out_share}, 32'h3A);
        chk("reseed_valid_kept", {31'd0, out_valid}, 32'd1);
        chk("reseed_cnt_kept", {28'd0, pair_cnt}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            chk("rewarm_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        chk("rewarm_done", {31'd0, busy}, 32'd0);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_share_held", {24'd0, out_share}, 32'h3A);

        // Pop and accept in the same cycle
        out_ready = 1'b1;
        #1;
        chk("pt_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("pt_share", {24'd0, out_share}, 32'hEB);
        chk("pt_cnt", {28'd0, pair_cnt}, 32'd4);

        // Backpressure: offer 0 while EB is stalled
        out_ready = 1'b0; in_data = 4'h0;
        #1;
        chk("bp2_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bp2_share_held", {24'd0, out_share}, 32'hEB);
        chk("bp2_cnt", {28'd0, pair_cnt}, 32'd4);
        out_ready = 1'b1;
        #1;
        chk("bp2_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp2_share", {24'd0, out_share}, 32'h77);
        chk("bp2_cnt2", {28'd0, pair_cnt}, 32'd5);

        // Asynchronous reset mid-stream, between clock edges
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_cnt", {28'd0, pair_cnt}, 32'd0);
        chk("arst_share", {24'd0, out_share}, 32'h00);
        chk("arst_busy", {31'd0, busy}, 32'd1);
        tick();
        rst = 1'b0;

        // Random stream
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            tick();
            waitc++;
        end
        chk("rand_ready_timeout", {31'd0, in_ready}, 32'd1);

        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 40000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_spurious_pair", 32'd0, 32'd1);
                end else begin
                    x = q.pop_front();
                    chk("rand_invariant", {28'd0, out_share[3:0] ^ out_share[7:4]}, {28'd0, x});
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                acc++;
            end
            tick();
            chk("rand_cnt", {28'd0, pair_cnt}, {28'd0, acc[3:0]});
            cyc++;
        end
        chk("rand_completed", (acc >= 10000) ? 32'd1 : 32'd0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
